// File: rtl/mux4_rr_arbiter_if.sv
// Handshake and data bundle between the four requesters and the shared 4:1 mux arbiter.
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       req;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] y;
    logic             valid;
    logic             busy;

    modport master (
        output req, d0, d1, d2, d3,
        input  gnt, sel, y, valid, busy
    );

    modport slave (
        input  req, d0, d1, d2, d3,
        output gnt, sel, y, valid, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 mux: grants one requester at a time,
// drives the mux select and registers the selected data with a valid flag.
module mux4_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    mux4_rr_arbiter_if.slave  bus
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [1:0]       last;
    logic [HW-1:0]    hold_cnt;
    logic [1:0]       pick;
    logic             others;
    logic [WIDTH-1:0] d_sel;

    // First requester found scanning last+1 .. last+4 (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] idx;
        logic       found;
        rr_pick = l;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = l + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        pick   = rr_pick(bus.req, last);
        others = |(bus.req & ~(4'b0001 << bus.sel));
        d_sel  = bus.d0;
        case (bus.sel)
            2'd0:    d_sel = bus.d0;
            2'd1:    d_sel = bus.d1;
            2'd2:    d_sel = bus.d2;
            default: d_sel = bus.d3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 2'd3;
            hold_cnt  <= '0;
            bus.gnt   <= 4'b0000;
            bus.sel   <= 2'd0;
            bus.y     <= '0;
            bus.valid <= 1'b0;
            bus.busy  <= 1'b0;
        end else begin
            // Data stage trails the grant by one edge.
            bus.valid <= |bus.gnt;
            if (|bus.gnt)
                bus.y <= d_sel;

            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        bus.gnt  <= 4'b0001 << pick;
                        bus.sel  <= pick;
                        last     <= pick;
                        hold_cnt <= HW'(1);
                        bus.busy <= 1'b1;
                        state    <= GRANT;
                    end
                end
                default: begin
                    // A dropped request or an expired hold under contention hands over
                    // without an idle bubble; last==sel keeps the holder out of the pick.
                    if ((!bus.req[bus.sel] && others) ||
                        (bus.req[bus.sel] && others && hold_cnt == HW'(MAX_HOLD))) begin
                        bus.gnt  <= 4'b0001 << pick;
                        bus.sel  <= pick;
                        last     <= pick;
                        hold_cnt <= HW'(1);
                    end else if (!bus.req[bus.sel]) begin
                        bus.gnt  <= 4'b0000;
                        bus.busy <= 1'b0;
                        hold_cnt <= '0;
                        state    <= IDLE;
                    end else if (hold_cnt != HW'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (WIDTH=8, MAX_HOLD=4) with hand-computed expectations.
module tb_mux4_rr_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    mux4_rr_arbiter_if #(.WIDTH(8)) bus ();

    mux4_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {gnt, sel, y, valid, busy}
    function automatic logic [31:0] status();
        return {16'd0, bus.gnt, bus.sel, bus.y, bus.valid, bus.busy};
    endfunction

    logic [7:0] dv [4];
    int         idx;
    int         prev;

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        bus.req = 4'b0000;
        bus.d0  = 8'h00;
        bus.d1  = 8'h00;
        bus.d2  = 8'h00;
        bus.d3  = 8'h00;

        // 1: reset and idle
        tick();
        tick();
        chk("reset_state", status(), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_after_reset", status(), 32'h0);
        end

        // 2: single requester 2
        bus.req = 4'b0100;
        bus.d2  = 8'hA5;
        tick();
        chk("t2_gnt", bus.gnt, 4'b0100);
        chk("t2_sel", bus.sel, 2'd2);
        chk("t2_busy", bus.busy, 1'b1);
        chk("t2_valid_early", bus.valid, 1'b0);
        tick();
        chk("t2_y", bus.y, 8'hA5);
        chk("t2_valid", bus.valid, 1'b1);
        bus.req = 4'b0000;
        tick();
        chk("t2_gnt_drop", bus.gnt, 4'b0000);
        chk("t2_busy_drop", bus.busy, 1'b0);
        chk("t2_valid_lag", bus.valid, 1'b1);
        tick();
        chk("t2_valid_drop", bus.valid, 1'b0);
        chk("t2_y_hold", bus.y, 8'hA5);

        // 3: full contention from fresh reset priority
        rst = 1'b1;
        #2;
        rst = 1'b0;
        dv[0] = 8'h10; dv[1] = 8'h21; dv[2] = 8'h32; dv[3] = 8'h43;
        bus.d0 = dv[0]; bus.d1 = dv[1]; bus.d2 = dv[2]; bus.d3 = dv[3];
        bus.req = 4'b1111;
        prev = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            idx = ((n - 1) / 4) % 4;
            chk("t3_gnt", bus.gnt, 4'b0001 << idx);
            chk("t3_sel", bus.sel, idx);
            if (n >= 2)
                chk("t3_y", bus.y, dv[prev]);
            prev = idx;
        end

        // 4: holder 0 drops to 1, then 1 drops while 3 asks
        bus.req = 4'b0010;
        tick();
        chk("t4_gnt1", bus.gnt, 4'b0010);
        bus.req = 4'b1000;
        tick();
        chk("t4_gnt3", bus.gnt, 4'b1000);
        chk("t4_busy", bus.busy, 1'b1);
        chk("t4_valid", bus.valid, 1'b1);
        chk("t4_y", bus.y, dv[1]);

        // 5: lone requester 0 keeps the grant
        bus.req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t5_hold", bus.gnt, 4'b0001);
        end
        bus.req = 4'b1001;
        tick();
        chk("t5_rotate", bus.gnt, 4'b1000);
        chk("t5_sel", bus.sel, 2'd3);

        // 6: async reset between edges
        #3;
        rst = 1'b1;
        #1;
        chk("t6_async_clear", status(), 32'h0);
        bus.req = 4'b1010;
        tick();
        chk("t6_held_in_reset", status(), 32'h0);
        rst = 1'b0;
        tick();
        chk("t6_first_gnt", bus.gnt, 4'b0010);
        chk("t6_first_sel", bus.sel, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
